// File: rtl/mc_pkg.sv
// Shared definitions for the memory-controller block family.
//   - Default address / data widths (also used by mc_top).
//   - Instruction word size in bytes.
//   - Prefetch FSM state encoding.
package mc_pkg;

  localparam int MC_ADDR_W     = 32;
  localparam int MC_DATA_W     = 32;
  localparam int MC_INST_BYTES = 4;

  // FETCH: normal sequential fetching.
  // DRAIN: a redirect hit while a request was outstanding; the request is
  //        held until its ack, whose data is thrown away.
  typedef enum logic {
    MC_PF_FETCH = 1'b0,
    MC_PF_DRAIN = 1'b1
  } mc_pf_state_e;

endpackage

// File: rtl/mc_sync_fifo.sv
// Synchronous FIFO with a registered head.
//   clk, rst         : clock, synchronous active-high reset
//   flush            : clears contents next cycle (wins over push/pop)
//   push, push_data  : write one entry (ignored when full without a pop)
//   pop              : remove the head (ignored when empty)
//   head_valid       : registered, FIFO non-empty
//   head_data        : registered copy of the oldest entry
//   count_next       : occupancy after this cycle's flush/push/pop
// A pushed word becomes visible on head_data one cycle later at the
// earliest; there is no push-to-head bypass.
module mc_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CNT_W-1:0] count, cnt_n;
  logic             head_valid_n;
  logic [WIDTH-1:0] head_data_n;
  logic             full, empty, do_pop, do_push;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_n     = rd_ptr + PTR_W'(do_pop);
    wr_ptr_n     = wr_ptr + PTR_W'(do_push);
    cnt_n        = count + CNT_W'(do_push) - CNT_W'(do_pop);
    head_valid_n = 1'b0;
    head_data_n  = head_data;
    if (flush) begin
      rd_ptr_n    = '0;
      wr_ptr_n    = '0;
      cnt_n       = '0;
      head_data_n = '0;
    end else if (cnt_n != '0) begin
      head_valid_n = 1'b1;
      // The slot that becomes the head is being written this very cycle
      // exactly when the FIFO is otherwise empty after the pop.
      if (do_push && (wr_ptr == rd_ptr_n)) begin
        head_data_n = push_data;
      end else begin
        head_data_n = mem[rd_ptr_n];
      end
    end
  end

  assign count_next = cnt_n;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count      <= cnt_n;
      head_valid <= head_valid_n;
      head_data  <= head_data_n;
    end
  end

endmodule

// File: rtl/mc_inst_prefetch.sv
// Instruction prefetch stage in front of the memory controller's
// instruction port.
//   sys_clk, sys_rst      : clock, synchronous active-high reset
//   core_redirect_i/addr  : one-cycle flush + restart at a new address
//   core_inst_valid_o/ready_i/data_o/addr_o : instruction stream to core
//   mem_inst_stb_o/addr_o : fetch request to the memory controller
//   mem_inst_ack_i/data_i : fetch completion (same-cycle as stb)
//   dbg_state_o           : current FSM state (0 = FETCH, 1 = DRAIN)
//
// Memory handshake: a request is presented by stb=1 with addr; both stay
// stable until the cycle in which ack=1, which is the transfer cycle. Ack
// with stb=0 is ignored. At most one request is ever outstanding.
// Core handshake: a word leaves the FIFO in any cycle with valid && ready,
// unless a redirect is present in the same cycle.
module mc_inst_prefetch
  import mc_pkg::*;
#(
  parameter int                ADDR_W   = MC_ADDR_W,
  parameter int                DATA_W   = MC_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              core_redirect_i,
  input  logic [ADDR_W-1:0] core_redirect_addr_i,
  output logic              core_inst_valid_o,
  input  logic              core_inst_ready_i,
  output logic [DATA_W-1:0] core_inst_data_o,
  output logic [ADDR_W-1:0] core_inst_addr_o,
  output logic              mem_inst_stb_o,
  output logic [ADDR_W-1:0] mem_inst_addr_o,
  input  logic              mem_inst_ack_i,
  input  logic [DATA_W-1:0] mem_inst_data_i,
  output logic              dbg_state_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  mc_pf_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              stb_q, stb_d;
  logic [ADDR_W-1:0] redirect_pc;
  logic              xfer, fifo_push, fifo_pop;
  logic [CNT_W-1:0]  count_next;
  logic [ENT_W-1:0]  head;

  // Low address bits are masked rather than sliced so every input bit is used.
  assign redirect_pc = core_redirect_addr_i & ~ADDR_W'(MC_INST_BYTES - 1);
  assign xfer        = stb_q && mem_inst_ack_i;
  // Redirect wins over both the returning word and a core pop.
  assign fifo_push   = xfer && (state_q == MC_PF_FETCH) && !core_redirect_i;
  assign fifo_pop    = core_inst_valid_o && core_inst_ready_i && !core_redirect_i;

  mc_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .flush      (core_redirect_i),
    .push       (fifo_push),
    .push_data  ({addr_q, mem_inst_data_i}),
    .pop        (fifo_pop),
    .head_valid (core_inst_valid_o),
    .head_data  (head),
    .count_next (count_next)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stb_d      = 1'b0;
    addr_d     = addr_q;
    if (state_q == MC_PF_FETCH) begin
      if (core_redirect_i) begin
        fetch_pc_d = redirect_pc;
        // An un-acked request cannot be withdrawn; wait out its ack.
        if (stb_q && !mem_inst_ack_i) begin
          state_d = MC_PF_DRAIN;
        end
      end else if (xfer) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(MC_INST_BYTES);
      end
    end else begin
      if (core_redirect_i) begin
        fetch_pc_d = redirect_pc;
      end
      if (xfer) begin
        state_d = MC_PF_FETCH;
      end
    end

    if (state_d == MC_PF_DRAIN) begin
      stb_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      // Evaluated on next-cycle values so an ack cycle can re-issue at once.
      stb_d  = (count_next < CNT_W'(DEPTH));
      addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= MC_PF_FETCH;
      fetch_pc_q <= RESET_PC;
      stb_q      <= 1'b0;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stb_q      <= stb_d;
      addr_q     <= addr_d;
    end
  end

  assign mem_inst_stb_o   = stb_q;
  assign mem_inst_addr_o  = addr_q;
  assign core_inst_data_o = head[DATA_W-1:0];
  assign core_inst_addr_o = head[DATA_W +: ADDR_W];
  assign dbg_state_o      = state_q;

endmodule
